// File: rtl/prog_mem_boot_ctrl.sv
// Program memory port owner: shares the memory address/write port between CPU
// instruction fetch (RUN) and a little-endian byte-stream boot loader (LOAD).
module prog_mem_boot_ctrl #(
    parameter int          MEMORY_DEPTH = 128,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] TEXT_BASE    = 32'h0040_0000,
    localparam int         ADDR_W       = $clog2(MEMORY_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  boot_start,
    input  logic                  run_req,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [31:0]           cpu_pc,
    output logic                  cpu_stall,
    output logic                  addr_fault,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic [ADDR_W:0]       load_count,
    output logic                  boot_done,
    output logic                  load_err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        DONE,
        RUN
    } state_t;

    state_t            state;
    logic [7:0]        n_lo;
    logic [ADDR_W:0]   n_words;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_buf;
    logic [ADDR_W-1:0] word_idx;

    logic              rx_fire;
    logic [15:0]       hdr_n;
    logic [ADDR_W:0]   next_count;
    logic [29:0]       off_word;
    logic              pc_fault;

    assign rx_fire    = rx_valid & rx_ready;
    assign hdr_n      = {rx_data, n_lo};
    assign next_count = {1'b0, word_idx} + {{ADDR_W{1'b0}}, 1'b1};

    // TEXT_BASE is word aligned, so the word offset can be taken from the
    // upper PC bits directly; a misaligned PC is a fault and forces index 0.
    always_comb begin
        off_word   = cpu_pc[31:2] - TEXT_BASE[31:2];
        pc_fault   = (cpu_pc[1:0] != 2'b00) ||
                     (cpu_pc < TEXT_BASE) ||
                     ({2'b00, off_word} >= 32'(MEMORY_DEPTH));
        addr_fault = 1'b0;
        mem_addr   = word_idx;
        if (state == RUN) begin
            addr_fault = pc_fault;
            mem_addr   = pc_fault ? '0 : off_word[ADDR_W-1:0];
        end
    end

    // Control outputs are registered alongside each state transition, so they
    // always reflect the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cpu_stall  <= 1'b1;
            rx_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            load_count <= '0;
            boot_done  <= 1'b0;
            load_err   <= 1'b0;
            n_lo       <= '0;
            n_words    <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            word_idx   <= '0;
        end else begin
            mem_we    <= 1'b0;
            boot_done <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (boot_start) begin
                        state      <= HDR0;
                        cpu_stall  <= 1'b1;
                        rx_ready   <= 1'b1;
                        load_err   <= 1'b0;
                        load_count <= '0;
                        byte_cnt   <= '0;
                        word_idx   <= '0;
                    end else if (state == IDLE && run_req) begin
                        state     <= RUN;
                        cpu_stall <= 1'b0;
                    end
                end
                HDR0: begin
                    if (rx_fire) begin
                        n_lo  <= rx_data;
                        state <= HDR1;
                    end
                end
                HDR1: begin
                    if (rx_fire) begin
                        if (hdr_n == 16'd0) begin
                            state     <= DONE;
                            rx_ready  <= 1'b0;
                            boot_done <= 1'b1;
                        end else if (hdr_n > 16'(MEMORY_DEPTH)) begin
                            state    <= IDLE;
                            rx_ready <= 1'b0;
                            load_err <= 1'b1;
                        end else begin
                            state   <= DATA;
                            n_words <= hdr_n[ADDR_W:0];
                        end
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                mem_wdata <= DATA_WIDTH'({rx_data, word_buf});
                                mem_we    <= 1'b1;
                                rx_ready  <= 1'b0;
                                state     <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    load_count <= next_count;
                    // The index is only advanced when another word follows,
                    // so a full-depth load never wraps back to zero.
                    if (next_count == n_words) begin
                        state     <= DONE;
                        boot_done <= 1'b1;
                    end else begin
                        state    <= DATA;
                        word_idx <= next_count[ADDR_W-1:0];
                        rx_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= RUN;
                    cpu_stall <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cpu_stall <= 1'b1;
                    rx_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule
